// File: rtl/mul_operand_queue_if.sv
// Handshake bundle for mul_operand_queue.
//   slave  : the queue side (accepts pairs on in_*, presents the head on out_*).
//   master : the environment side (producer on in_*, multiplier on out_*).
// Signals:
//   flush                          synchronous queue clear
//   in_valid/in_ready              producer handshake
//   in_a/in_b/in_signed            operand pair being offered
//   out_valid/out_ready            consumer handshake
//   out_a/out_b/out_signed         head pair, zero when out_valid=0
//   count                          number of valid entries, 0..DEPTH
interface mul_operand_queue_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_signed;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_signed, count
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_a, out_b, out_signed, count
  );
endinterface

// File: rtl/mul_operand_queue.sv
// DEPTH-entry FIFO of {A, B, signed} operand pairs feeding the multiplier.
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous, active-high; clears pointers, count and storage
//   bus    mul_operand_queue_if.slave: flush, producer and consumer handshakes, count
// No bypass path: a pair pushed into an empty queue appears on out_* one cycle later.
// No pass-through at full: in_ready depends only on the registered count.
module mul_operand_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  mul_operand_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Entry layout: {a, b, signed}
  typedef logic [2*WIDTH:0] entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;
  entry_t head;

  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Stale storage is masked so the consumer never sees old data while empty.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = out_valid;
    bus.out_a      = head[2*WIDTH:WIDTH+1];
    bus.out_b      = head[WIDTH:1];
    bus.out_signed = head[0];
    bus.count      = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.flush) begin
      // Storage is left as-is; count=0 already hides it.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_signed};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end
endmodule

// File: doc/mul_operand_queue.md
# mul_operand_queue

Parametrised operand-pair queue in front of the multiplier datapath. It generalises the single-entry 64-bit operand register into a DEPTH-entry FIFO of {A, B, signed} operand pairs with valid/ready handshakes on both sides and a synchronous flush. The upstream issue logic can then run ahead of the multiplier without losing operands.

## Interface
- WIDTH, 64, operand width in bits (>= 1).
- DEPTH, 4, number of operand-pair entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), count width (derived, not overridable).

- clk  in  1  clock; all state changes on posedge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous queue clear, active-high.
- in_valid  in  1  producer has an operand pair.
- in_ready  out  1  queue can accept a pair this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_signed  in  1  pair is to be multiplied as signed.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  multiplier consumes head this cycle.
- out_a  out  WIDTH  head operand A; zero when out_valid=0.
- out_b  out  WIDTH  head operand B; zero when out_valid=0.
- out_signed  out  1  head signed flag; zero when out_valid=0.
- count  out  CW  number of valid entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of WIDTH+WIDTH+1 bits, with a write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits, natural wrap DEPTH-1 -> 0) and a count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both are combinational from registered count only; neither depends on in_valid or out_ready.
- On push: entry[wr_ptr] <= {in_a, in_b, in_signed}; wr_ptr increments.
- On pop: rd_ptr increments.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- When full, in_ready=0, so there is no push even if a pop occurs that cycle. There is no pass-through at full.
- When empty, no pop occurs and there is no bypass: a pushed pair first appears at the output the next cycle.
- Output mux: out_* = entry[rd_ptr] when count != 0, else all zero.
- Data is stored unmodified. The block performs no sign extension or arithmetic on operands; out_signed travels with the pair.
- flush: wr_ptr, rd_ptr and count go to 0 on the next edge. Any push or pop in the flush cycle is discarded. Storage contents are not cleared, but outputs read zero because count=0.
- reset: same as flush, and additionally clears all storage entries to 0. reset has priority over flush.
- in_valid while in_ready=0 is legal backpressure. The producer holds its data, and the block does not capture it.

## Timing
- All outputs take their reset values on the first edge with reset=1: in_ready=1, out_valid=0, out_a=0, out_b=0, out_signed=0, count=0.
- Push-to-output latency is 1 cycle. A pair pushed at edge N is visible on out_* after edge N with out_valid=1, provided it is the head.
- Throughput is 1 push and 1 pop per cycle sustained whenever 0 < count < DEPTH.
- Output data is stable while out_valid=1 and out_ready=0.
- Reset or flush asserted mid-operation takes effect on that edge, regardless of handshakes. in_ready=1 and out_valid=0 hold the following cycle.
- Pointer wrap is seamless: FIFO order is preserved across the DEPTH-1 -> 0 boundary.

## Test plan
- Reset: drive reset=1 for 2 cycles with in_valid=1 -> count=0, in_ready=1, out_valid=0, out_a=out_b=0 throughout and the cycle after release.
- Fill/drain (DEPTH=4, WIDTH=64): push A=1..5, B=0x10..0x14 with out_ready=0 -> in_ready drops after the 4th push, the 5th is held, and count=4. Then set out_ready=1 -> pairs (1,0x10)..(5,0x14) emerge in order, and out_valid drops with count=0.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data -> count stays 2, output order is strictly FIFO, and pointers wrap at least twice with no loss or duplication.
- Full plus pop: at count=4 assert in_valid and out_ready together -> one pop, no push, count=3. The next cycle's push is accepted.
- Flush: at count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_a=0. The pushed pair is not stored.
- Signed flag and full width: push A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h8000_0000_0000_0000, signed=1, then A=0, B=1, signed=0 -> outputs match bit-exactly, including out_signed per entry.
